mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported 32x32 word memory between the instruction-fetch port (PC/fetch side)
//  and the load/store port (datapath side). Registered req/gnt/valid handshake per port,
//  fixed data-side priority with fetch anti-starvation; drives memory read/write strobes.
//  Sits between the fetch/datapath logic and the memory array.
// PARAMETERS
//  ADDR_W      5   word address width (32 words)
//  DATA_W      32  data word width
//  MEM_LAT     1   memory access cycles per transaction (>=1)
//  STARVE_MAX  3   consecutive fetch losses before fetch is forced to win (>=1)
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  reset       in   1       synchronous, active-high reset
//  if_req      in   1       fetch read request; held until if_gnt seen
//  if_addr     in   ADDR_W  fetch word address
//  if_gnt      out  1       one-cycle pulse: fetch request accepted
//  if_valid    out  1       one-cycle pulse: if_rdata valid
//  if_rdata    out  DATA_W  fetch read data, held until next fetch completion
//  dm_req      in   1       data request; held until dm_gnt seen
//  dm_we       in   1       1 = write, 0 = read
//  dm_addr     in   ADDR_W  data word address
//  dm_wdata    in   DATA_W  data write value
//  dm_gnt      out  1       one-cycle pulse: data request accepted
//  dm_valid    out  1       one-cycle pulse: read data valid / write done
//  dm_rdata    out  DATA_W  data read value; unchanged by writes
//  mem_read    out  1       memory read strobe
//  mem_write   out  1       memory write strobe (memory writes on rising edge while high)
//  mem_addr    out  ADDR_W  memory word address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, combinational from mem_addr
//  stat_if_cnt, stat_dm_cnt, stat_promo_cnt  out 16 each  statistics (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, starve counter 0. A transaction in flight is dropped;
//    no gnt/valid is produced for it.
//  - FSM: IDLE -> ACCESS (MEM_LAT cycles) -> RESP -> IDLE. Requests sampled only in IDLE.
//  - IDLE, edge T: if any req, latch owner, addr, we, wdata; go ACCESS. Owner's gnt is 1 in cycle T+1 only.
//  - ACCESS: mem_addr = latched addr. Read: mem_read=1 all MEM_LAT cycles. Write: mem_write=1
//    only in the final ACCESS cycle. Read data captured from mem_rdata at the end of the final cycle.
//  - RESP: owner's valid=1 for one cycle, rdata updated (reads only). Then IDLE.
//  - Latency req->gnt 1 cycle; gnt->valid MEM_LAT cycles. One transaction per MEM_LAT+2 cycles.
//  - Arbitration when both req in IDLE: dm wins unless starve_cnt == STARVE_MAX, then if wins.
//  - starve_cnt: +1 when if_req loses to dm (saturating at STARVE_MAX); cleared on any if grant.
//  - Requester may drop req/addr after seeing gnt; inputs are ignored outside IDLE.
//  - mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
// CONFIGURATION
//  - ARB_STATS_EN defined: 16-bit wrapping counters: stat_if_cnt +1 per if grant,
//    stat_dm_cnt +1 per dm grant, stat_promo_cnt +1 per starvation-forced if grant. All cleared by reset.
//  - ARB_STATS_EN undefined: stat_* ports exist and are tied to 0; no counter flops.
// STRUCTURE
//  - Shared header arb_defs.vh: FSM state encodings (IDLE/ACCESS/RESP), owner codes (OWN_IF/OWN_DM).
//  - One sub-module arb_starve_ctr: the saturating starve counter with inc/clear/at_max.
//  - All other logic lives in mem_port_arbiter.
// TESTING (MEM_LAT=1, STARVE_MAX=3, memory preloaded data[i]=i)
//  1. Hold reset 2 cycles with both reqs high -> all outputs 0; first gnt 1 cycle after reset drops.
//  2. if_req, if_addr=5 -> if_gnt at T+1, mem_read=1 with mem_addr=5, if_valid at T+2, if_rdata=5.
//  3. dm write 0xDEADBEEF to addr 3, then dm read addr 3 -> dm_valid, dm_rdata=0xDEADBEEF;
//     dm_rdata unchanged after the write's dm_valid.
//  4. Both reqs held continuously -> grant order dm,dm,dm,if,dm,dm,dm,if...
//  5. MEM_LAT=3, dm write addr 7 = 0x55; reset in 2nd ACCESS cycle -> no mem_write, no dm_valid, data[7]=7.
//  6. With ARB_STATS_EN, run scenario 4 for 8 grants -> stat_dm_cnt=6, stat_if_cnt=2, stat_promo_cnt=2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory port arbiter:
// FSM state and owner encodings plus a counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnDm = 1'b1
    } arb_owner_e;

    localparam int unsigned StatW = 16;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating fetch-starvation counter: counts fetch losses to the data port,
// reports when the limit is reached, cleared whenever fetch is granted.
module mem_port_arbiter_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CntW = cnt_width(STARVE_MAX);

    logic [CntW-1:0] cnt_q;

    assign at_max = (cnt_q == CntW'(STARVE_MAX));

    // Clear has priority over increment; increment saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported word memory between the fetch port and the
// load/store port. Data side wins ties unless fetch has lost STARVE_MAX times
// in a row. Each transaction: IDLE -> ACCESS (MEM_LAT cycles) -> RESP -> IDLE.
// Build option: define ARB_STATS_EN to enable the 16-bit grant statistics
// counters; otherwise the stat_* ports are tied to zero.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [StatW-1:0]  stat_if_cnt,
    output logic [StatW-1:0]  stat_dm_cnt,
    output logic [StatW-1:0]  stat_promo_cnt
);

    localparam int unsigned LatW = cnt_width(MEM_LAT - 1);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LatW-1:0]   lat_q;
    logic              if_gnt_q, dm_gnt_q, if_valid_q, dm_valid_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    logic starve_at_max;
    logic lat_last, take, pick_if, if_win, dm_win, if_lost, promo, done;

    assign lat_last = (lat_q == LatW'(MEM_LAT - 1));
    assign take     = (state_q == StIdle) && (if_req || dm_req);
    assign pick_if  = if_req && (!dm_req || starve_at_max);
    assign if_win   = take && pick_if;
    assign dm_win   = take && !pick_if;
    assign if_lost  = dm_win && if_req;
    assign promo    = if_win && dm_req;
    assign done     = (state_q == StAccess) && lat_last;

    mem_port_arbiter_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc    (if_lost),
        .clr    (if_win),
        .at_max (starve_at_max)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (take) state_d = StAccess;
            StAccess: if (lat_last) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Memory strobes: reads strobe every ACCESS cycle, writes only the last one.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == StAccess) begin
            mem_addr  = addr_q;
            mem_read  = !we_q;
            mem_write = we_q && lat_last;
            mem_wdata = we_q ? wdata_q : '0;
        end
    end

    // Transaction capture, latency count, handshake pulses and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OwnIf;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            if_gnt_q   <= 1'b0;
            dm_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (take) begin
                owner_q <= pick_if ? OwnIf : OwnDm;
                we_q    <= pick_if ? 1'b0 : dm_we;
                addr_q  <= pick_if ? if_addr : dm_addr;
                wdata_q <= pick_if ? '0 : dm_wdata;
            end
            lat_q      <= ((state_q == StAccess) && !lat_last) ? lat_q + 1'b1 : '0;
            if_gnt_q   <= if_win;
            dm_gnt_q   <= dm_win;
            if_valid_q <= done && (owner_q == OwnIf);
            dm_valid_q <= done && (owner_q == OwnDm);
            if (done && !we_q) begin
                if (owner_q == OwnIf) begin
                    if_rdata_q <= mem_rdata;
                end else begin
                    dm_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_gnt   = if_gnt_q;
    assign dm_gnt   = dm_gnt_q;
    assign if_valid = if_valid_q;
    assign dm_valid = dm_valid_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

`ifdef ARB_STATS_EN
    logic [StatW-1:0] stat_if_q, stat_dm_q, stat_promo_q;

    // Wrapping grant statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_if_q    <= '0;
            stat_dm_q    <= '0;
            stat_promo_q <= '0;
        end else begin
            if (if_win) stat_if_q    <= stat_if_q + 1'b1;
            if (dm_win) stat_dm_q    <= stat_dm_q + 1'b1;
            if (promo)  stat_promo_q <= stat_promo_q + 1'b1;
        end
    end

    assign stat_if_cnt    = stat_if_q;
    assign stat_dm_cnt    = stat_dm_q;
    assign stat_promo_cnt = stat_promo_q;
`else
    assign stat_if_cnt    = '0;
    assign stat_dm_cnt    = '0;
    assign stat_promo_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Instance a uses MEM_LAT=1,
// instance b uses MEM_LAT=3. Memories are preloaded with data[i]=i.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic preload;
    logic reset_a, reset_b;

    // Instance a (MEM_LAT = 1)
    logic        a_if_req, a_if_gnt, a_if_valid;
    logic [4:0]  a_if_addr;
    logic [31:0] a_if_rdata;
    logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_valid;
    logic [4:0]  a_dm_addr;
    logic [31:0] a_dm_wdata, a_dm_rdata;
    logic        a_mem_read, a_mem_write;
    logic [4:0]  a_mem_addr;
    logic [31:0] a_mem_wdata, a_mem_rdata;
    logic [15:0] a_stat_if, a_stat_dm, a_stat_promo;
    logic [31:0] a_mem [32];
    int          a_both_cnt = 0;

    // Instance b (MEM_LAT = 3)
    logic        b_if_req, b_if_gnt, b_if_valid;
    logic [4:0]  b_if_addr;
    logic [31:0] b_if_rdata;
    logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_valid;
    logic [4:0]  b_dm_addr;
    logic [31:0] b_dm_wdata, b_dm_rdata;
    logic        b_mem_read, b_mem_write;
    logic [4:0]  b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;
    logic [15:0] b_stat_if, b_stat_dm, b_stat_promo;
    logic [31:0] b_mem [32];
    int          b_write_cnt = 0;

    mem_port_arbiter #(
        .ADDR_W (5), .DATA_W (32), .MEM_LAT (1), .STARVE_MAX (3)
    ) dut_a (
        .clk (clk), .reset (reset_a),
        .if_req (a_if_req), .if_addr (a_if_addr), .if_gnt (a_if_gnt),
        .if_valid (a_if_valid), .if_rdata (a_if_rdata),
        .dm_req (a_dm_req), .dm_we (a_dm_we), .dm_addr (a_dm_addr), .dm_wdata (a_dm_wdata),
        .dm_gnt (a_dm_gnt), .dm_valid (a_dm_valid), .dm_rdata (a_dm_rdata),
        .mem_read (a_mem_read), .mem_write (a_mem_write), .mem_addr (a_mem_addr),
        .mem_wdata (a_mem_wdata), .mem_rdata (a_mem_rdata),
        .stat_if_cnt (a_stat_if), .stat_dm_cnt (a_stat_dm), .stat_promo_cnt (a_stat_promo)
    );

    mem_port_arbiter #(
        .ADDR_W (5), .DATA_W (32), .MEM_LAT (3), .STARVE_MAX (3)
    ) dut_b (
        .clk (clk), .reset (reset_b),
        .if_req (b_if_req), .if_addr (b_if_addr), .if_gnt (b_if_gnt),
        .if_valid (b_if_valid), .if_rdata (b_if_rdata),
        .dm_req (b_dm_req), .dm_we (b_dm_we), .dm_addr (b_dm_addr), .dm_wdata (b_dm_wdata),
        .dm_gnt (b_dm_gnt), .dm_valid (b_dm_valid), .dm_rdata (b_dm_rdata),
        .mem_read (b_mem_read), .mem_write (b_mem_write), .mem_addr (b_mem_addr),
        .mem_wdata (b_mem_wdata), .mem_rdata (b_mem_rdata),
        .stat_if_cnt (b_stat_if), .stat_dm_cnt (b_stat_dm), .stat_promo_cnt (b_stat_promo)
    );

    // Memory arrays: combinational read, write on rising edge while strobed.
    assign a_mem_rdata = a_mem[a_mem_addr];
    assign b_mem_rdata = b_mem[b_mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) a_mem[i] <= i;
        end else if (a_mem_write) begin
            a_mem[a_mem_addr] <= a_mem_wdata;
        end
        if (a_mem_read && a_mem_write) a_both_cnt <= a_both_cnt + 1;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) b_mem[i] <= i;
        end else if (b_mem_write) begin
            b_mem[b_mem_addr] <= b_mem_wdata;
        end
        if (b_mem_write) b_write_cnt <= b_write_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_if_req = 1'b0; a_if_addr = '0; a_dm_req = 1'b0; a_dm_we = 1'b0;
        a_dm_addr = '0; a_dm_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0;
        b_dm_addr = '0; b_dm_wdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_a = 1'b1; reset_b = 1'b1; preload = 1'b1;
        step(); step();
        reset_a = 1'b0; reset_b = 1'b0; preload = 1'b0;
    endtask

    task automatic test_reset();
        logic [106:0] outs;
        idle_inputs();
        reset_a = 1'b1; reset_b = 1'b1; preload = 1'b1;
        a_if_req = 1'b1; a_if_addr = 5'd9; a_dm_req = 1'b1; a_dm_addr = 5'd10;
        for (int c = 0; c < 2; c++) begin
            step();
            outs = {a_if_gnt, a_if_valid, a_if_rdata, a_dm_gnt, a_dm_valid, a_dm_rdata,
                    a_mem_read, a_mem_write, a_mem_addr, a_mem_wdata};
            n_cmp++;
            if (outs !== '0) begin
                n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
            end
            n_cmp++;
            if ({a_stat_if, a_stat_dm, a_stat_promo} !== 48'd0) begin
                n_fail++; $display("FAIL reset_stats: got %h want 0",
                                   {a_stat_if, a_stat_dm, a_stat_promo});
            end
        end
        reset_a = 1'b0; reset_b = 1'b0; preload = 1'b0;
        step();
        n_cmp++;
        if ({a_dm_gnt, a_if_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL reset_first_gnt: got dm/if=%b want 10", {a_dm_gnt, a_if_gnt});
        end
    endtask

    task automatic test_fetch_read();
        apply_reset();
        a_if_req = 1'b1; a_if_addr = 5'd5;
        step();
        n_cmp++;
        if ({a_if_gnt, a_dm_gnt, a_mem_read, a_mem_write, a_mem_addr} !== {4'b1010, 5'd5}) begin
            n_fail++; $display("FAIL fetch_gnt: got gnt=%b read=%b write=%b addr=%0d want 1,1,0,5",
                               a_if_gnt, a_mem_read, a_mem_write, a_mem_addr);
        end
        a_if_req = 1'b0; a_if_addr = 5'd30;
        step();
        n_cmp++;
        if ({a_if_valid, a_if_gnt, a_if_rdata} !== {2'b10, 32'd5}) begin
            n_fail++; $display("FAIL fetch_valid: got valid=%b gnt=%b rdata=%0h want 1,0,5",
                               a_if_valid, a_if_gnt, a_if_rdata);
        end
        step();
        n_cmp++;
        if ({a_if_valid, a_mem_read, a_if_rdata} !== {2'b00, 32'd5}) begin
            n_fail++; $display("FAIL fetch_idle: got valid=%b read=%b rdata=%0h want 0,0,5",
                               a_if_valid, a_mem_read, a_if_rdata);
        end
    endtask

    task automatic test_dm_write_read();
        apply_reset();
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 5'd3; a_dm_wdata = 32'hDEADBEEF;
        step();
        n_cmp++;
        if ({a_dm_gnt, a_mem_write, a_mem_read, a_mem_addr, a_mem_wdata}
            !== {3'b110, 5'd3, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL dm_write_strobe: got gnt=%b wr=%b rd=%b addr=%0d wd=%h",
                               a_dm_gnt, a_mem_write, a_mem_read, a_mem_addr, a_mem_wdata);
        end
        a_dm_req = 1'b0;
        step();
        n_cmp++;
        if ({a_dm_valid, a_dm_rdata, a_mem[3]} !== {1'b1, 32'd0, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL dm_write_done: got valid=%b rdata=%h mem=%h want 1,0,deadbeef",
                               a_dm_valid, a_dm_rdata, a_mem[3]);
        end
        step();
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 5'd3;
        step();
        a_dm_req = 1'b0;
        step();
        n_cmp++;
        if ({a_dm_valid, a_dm_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL dm_read_back: got valid=%b rdata=%h want 1,deadbeef",
                               a_dm_valid, a_dm_rdata);
        end
        step();
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 5'd3; a_dm_wdata = 32'h1234;
        step();
        a_dm_req = 1'b0;
        step();
        n_cmp++;
        if ({a_dm_valid, a_dm_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL dm_rdata_hold: got valid=%b rdata=%h want 1,deadbeef",
                               a_dm_valid, a_dm_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit exp_if [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int ngnt = 0;
        apply_reset();
        a_if_req = 1'b1; a_if_addr = 5'd1; a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 5'd2;
        for (int c = 0; c < 40 && ngnt < 8; c++) begin
            step();
            if (a_if_gnt || a_dm_gnt) begin
                n_cmp++;
                if ({a_if_gnt, a_dm_gnt} !== {exp_if[ngnt], !exp_if[ngnt]}) begin
                    n_fail++; $display("FAIL grant_order[%0d]: got if/dm=%b%b want %b%b", ngnt,
                                       a_if_gnt, a_dm_gnt, exp_if[ngnt], !exp_if[ngnt]);
                end
                ngnt++;
            end
        end
        n_cmp++;
        if (ngnt != 8) begin
            n_fail++; $display("FAIL grant_count: got %0d want 8", ngnt);
        end
`ifdef ARB_STATS_EN
        n_cmp++;
        if ({a_stat_dm, a_stat_if, a_stat_promo} !== {16'd6, 16'd2, 16'd2}) begin
            n_fail++; $display("FAIL stats: got dm=%0d if=%0d promo=%0d want 6,2,2",
                               a_stat_dm, a_stat_if, a_stat_promo);
        end
`else
        n_cmp++;
        if ({a_stat_dm, a_stat_if, a_stat_promo} !== 48'd0) begin
            n_fail++; $display("FAIL stats_tied: got dm=%0d if=%0d promo=%0d want 0,0,0",
                               a_stat_dm, a_stat_if, a_stat_promo);
        end
`endif
        idle_inputs();
        step(); step(); step();
    endtask

    task automatic test_random();
        logic [31:0] shadow [32];
        logic [31:0] exp_if_rd = '0, exp_dm_rd = '0, wd;
        logic [4:0]  addr;
        bit          ip = 1'b0, dp = 1'b0, win_if, w;
        int          starve = 0, s_if = 0, s_dm = 0, s_pr = 0;
        apply_reset();
        for (int i = 0; i < 32; i++) shadow[i] = i;
        for (int r = 0; r < 120; r++) begin
            if (!ip && $urandom_range(1, 0) == 1) begin
                ip = 1'b1; a_if_req = 1'b1; a_if_addr = 5'($urandom);
            end
            if (!dp && $urandom_range(1, 0) == 1) begin
                dp = 1'b1; a_dm_req = 1'b1; a_dm_we = 1'($urandom);
                a_dm_addr = 5'($urandom); a_dm_wdata = $urandom;
            end
            if (!ip && !dp) begin
                step();
                n_cmp++;
                if ({a_if_gnt, a_dm_gnt, a_mem_read, a_mem_write} !== 4'b0) begin
                    n_fail++; $display("FAIL rnd_idle[%0d]: got gnt=%b%b rw=%b%b want 0",
                                       r, a_if_gnt, a_dm_gnt, a_mem_read, a_mem_write);
                end
                continue;
            end
            // Reference arbitration: data wins ties unless fetch lost 3 times running.
            win_if = ip && (!dp || starve == 3);
            if (win_if) begin
                starve = 0; s_if++;
                if (dp) s_pr++;
            end else begin
                s_dm++;
                if (ip && starve < 3) starve++;
            end
            w    = win_if ? 1'b0 : a_dm_we;
            addr = win_if ? a_if_addr : a_dm_addr;
            wd   = a_dm_wdata;
            step();
            n_cmp++;
            if ({a_if_gnt, a_dm_gnt, a_mem_read, a_mem_write, a_mem_addr}
                !== {win_if, !win_if, !w, w, addr}) begin
                n_fail++; $display("FAIL rnd_gnt[%0d]: got gnt=%b%b rw=%b%b a=%0d want %b%b %b%b %0d",
                                   r, a_if_gnt, a_dm_gnt, a_mem_read, a_mem_write, a_mem_addr,
                                   win_if, !win_if, !w, w, addr);
            end
            // Winner drops its request; scrambled inputs must be ignored now.
            if (win_if) begin
                ip = 1'b0; a_if_req = 1'b0; a_if_addr = 5'($urandom);
                exp_if_rd = shadow[addr];
            end else begin
                dp = 1'b0; a_dm_req = 1'b0; a_dm_addr = 5'($urandom);
                a_dm_wdata = $urandom; a_dm_we = 1'($urandom);
                if (w) shadow[addr] = wd;
                else   exp_dm_rd = shadow[addr];
            end
            step();
            n_cmp++;
            if ({a_if_valid, a_dm_valid, a_if_rdata, a_dm_rdata}
                !== {win_if, !win_if, exp_if_rd, exp_dm_rd}) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got v=%b%b if=%h dm=%h want %b%b %h %h",
                                   r, a_if_valid, a_dm_valid, a_if_rdata, a_dm_rdata,
                                   win_if, !win_if, exp_if_rd, exp_dm_rd);
            end
            step();
            n_cmp++;
            if ({a_if_valid, a_dm_valid, a_if_gnt, a_dm_gnt, a_mem_read, a_mem_write} !== 6'b0) begin
                n_fail++; $display("FAIL rnd_resp_end[%0d]: got nonzero handshake/strobe", r);
            end
        end
        n_cmp++;
        if (a_both_cnt !== 0) begin
            n_fail++; $display("FAIL rw_exclusive: got %0d overlaps want 0", a_both_cnt);
        end
`ifdef ARB_STATS_EN
        n_cmp++;
        if ({a_stat_if, a_stat_dm, a_stat_promo} !== {16'(s_if), 16'(s_dm), 16'(s_pr)}) begin
            n_fail++; $display("FAIL rnd_stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                               a_stat_if, a_stat_dm, a_stat_promo, s_if, s_dm, s_pr);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_latency3_and_abort();
        int  w0;
        bit  saw;
        apply_reset();
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 5'd4;
        step();
        n_cmp++;
        if ({b_dm_gnt, b_mem_read, b_mem_addr} !== {2'b11, 5'd4}) begin
            n_fail++; $display("FAIL lat3_gnt: got gnt=%b rd=%b a=%0d want 1,1,4",
                               b_dm_gnt, b_mem_read, b_mem_addr);
        end
        b_dm_req = 1'b0;
        for (int c = 1; c < 3; c++) begin
            step();
            n_cmp++;
            if ({b_dm_gnt, b_dm_valid, b_mem_read, b_mem_write} !== 4'b0010) begin
                n_fail++; $display("FAIL lat3_access[%0d]: got gnt=%b v=%b rd=%b wr=%b want 0,0,1,0",
                                   c, b_dm_gnt, b_dm_valid, b_mem_read, b_mem_write);
            end
        end
        step();
        n_cmp++;
        if ({b_dm_valid, b_mem_read, b_dm_rdata} !== {2'b10, 32'd4}) begin
            n_fail++; $display("FAIL lat3_valid: got v=%b rd=%b rdata=%h want 1,0,4",
                               b_dm_valid, b_mem_read, b_dm_rdata);
        end
        step();
        w0 = b_write_cnt;
        b_dm_req = 1'b1; b_dm_we = 1'b1; b_dm_addr = 5'd7; b_dm_wdata = 32'h55;
        step();
        b_dm_req = 1'b0;
        step();
        n_cmp++;
        if ({b_dm_gnt, b_mem_write} !== 2'b00) begin
            n_fail++; $display("FAIL abort_access2: got gnt=%b wr=%b want 0,0", b_dm_gnt, b_mem_write);
        end
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (b_dm_valid || b_dm_gnt || b_mem_write) saw = 1'b1;
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_response: got activity=1 want 0");
        end
        n_cmp++;
        if ({32'(b_write_cnt - w0), b_mem[7]} !== {32'd0, 32'd7}) begin
            n_fail++; $display("FAIL abort_mem: got writes=%0d data7=%h want 0,7",
                               b_write_cnt - w0, b_mem[7]);
        end
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; preload = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_read();
        test_dm_write_read();
        test_back_to_back();
        test_random();
        test_latency3_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
